// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: 16x oversampling, start-bit validation, 3-sample
// majority vote per bit, one-entry valid/ready holding register with error pulses.
module uart_rx_deframer #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RX_INVERT  = 0
) (
  input  logic       USER_CLK,
  input  logic       CPU_RESET,
  input  logic       FPGA_SERIAL_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned    DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned    CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_M1   = CW'(DIV - 1);
  localparam logic           INV      = (RX_INVERT != 0);
  localparam logic           IDLE_RAW = ~INV;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      s_q, s_d;
  logic [1:0]      smp_q, smp_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic rx_line;
  logic tick;
  logic decide;
  logic vote;
  logic complete;
  logic bad_stop;

  assign rx_line = sync_q[1] ^ INV;
  assign tick    = (tick_cnt_q == DIV_M1);
  assign decide  = tick && (s_q == 4'd9);
  // smp_q[1] holds the s=7 sample, smp_q[0] the s=8 sample; the live line is s=9
  assign vote    = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_line) | (smp_q[0] & rx_line);

  always_comb begin
    sync_d      = {sync_q[0], FPGA_SERIAL_RX};
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
    s_d         = tick ? s_q + 4'd1 : s_q;
    smp_d       = smp_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    complete    = 1'b0;
    bad_stop    = 1'b0;

    if (tick && (s_q == 4'd7)) smp_d[1] = rx_line;
    if (tick && (s_q == 4'd8)) smp_d[0] = rx_line;

    case (state_q)
      S_IDLE: begin
        if (!rx_line) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          s_d        = '0;
        end
      end
      S_START: begin
        if (decide) begin
          if (!vote) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // DATA is entered mid start bit; bit_cnt counts decisions taken, so the
        // start bit's own s=15 wrap is ignored and STOP follows bit 7's window.
        if (decide) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (tick && (s_q == 4'd15) && (bit_cnt_q == 4'd8)) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          state_d = S_IDLE;
          if (vote) complete = 1'b1;
          else      bad_stop = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    frame_err_d = bad_stop;
  end

  always_ff @(posedge USER_CLK or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      sync_q      <= {2{IDLE_RAW}};
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      s_q         <= '0;
      smp_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      s_q         <= s_d;
      smp_q       <= smp_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: a normal and an inverted-line instance see the same
// frames and are checked against a byte-level model of the holding register.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  // Parameters chosen for DIV = 4, so one bit lasts 64 clocks (640 ns at 10 ns clock)
  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 25000;
  localparam int unsigned BIT_NS = 640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       line;
  logic       line_inv;
  logic       rx_ready;
  logic [7:0] rx_data_v [2];
  logic [1:0] rx_valid_v, fe_v, ov_v, busy_v;

  assign line_inv = ~line;

  uart_rx_deframer #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .RX_INVERT(0)) u_dut (
    .USER_CLK(clk), .CPU_RESET(rst_n), .FPGA_SERIAL_RX(line),
    .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]), .rx_ready(rx_ready),
    .frame_err(fe_v[0]), .overrun(ov_v[0]), .busy(busy_v[0]));

  uart_rx_deframer #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .RX_INVERT(1)) u_dut_inv (
    .USER_CLK(clk), .CPU_RESET(rst_n), .FPGA_SERIAL_RX(line_inv),
    .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]), .rx_ready(rx_ready),
    .frame_err(fe_v[1]), .overrun(ov_v[1]), .busy(busy_v[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed behaviour, accumulated per instance
  logic [7:0] got_q [2][$];
  int         fe_cnt [2];
  int         ov_cnt [2];
  int         bad_cnt [2];
  logic [1:0] fe_prev, ov_prev;

  initial begin
    fe_prev = '0;
    ov_prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_n) begin
          if (rx_valid_v[i] && rx_ready) got_q[i].push_back(rx_data_v[i]);
          if (fe_v[i]) fe_cnt[i]++;
          if (ov_v[i]) ov_cnt[i]++;
          if ((fe_v[i] && ov_v[i]) || (fe_v[i] && fe_prev[i]) || (ov_v[i] && ov_prev[i]))
            bad_cnt[i]++;
        end
      end
      fe_prev = fe_v;
      ov_prev = ov_v;
    end
  end

  // Expected behaviour
  logic [7:0] exp_q [$];
  int         exp_fe;
  int         exp_ov;
  logic [7:0] batch_b [$];
  logic       batch_s [$];

  task automatic new_phase();
    for (int i = 0; i < 2; i++) begin
      got_q[i].delete();
      fe_cnt[i]  = 0;
      ov_cnt[i]  = 0;
      bad_cnt[i] = 0;
    end
    exp_q.delete();
    exp_fe = 0;
    exp_ov = 0;
  endtask

  task automatic idle(input int unsigned bits);
    line = 1'b1;
    #(BIT_NS * bits);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int unsigned nbits);
    line = 1'b0;
    #(BIT_NS / 2);
    for (int i = 0; i < 2; i++) check($sformatf("busy_mid_start%0d", i), busy_v[i], 1'b1);
    #(BIT_NS / 2);
    for (int unsigned k = 0; k < nbits; k++) begin
      line = b[k];
      #(BIT_NS);
    end
    if (nbits == 8) begin
      line = stop;
      #(BIT_NS);
      line = 1'b1;
    end
  endtask

  // Consumer always ready: good frames are delivered in order, bad stops only flag
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    else      exp_fe++;
    send(b, stop, 8);
    if (!stop) idle(2);
  endtask

  task automatic verify(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_count%0d", tag, i), got_q[i].size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        if (k < got_q[i].size())
          check($sformatf("%s_byte%0d_%0d", tag, k, i), got_q[i][k], exp_q[k]);
      check($sformatf("%s_frame_err%0d", tag, i), fe_cnt[i], exp_fe);
      check($sformatf("%s_overrun%0d", tag, i), ov_cnt[i], exp_ov);
      check($sformatf("%s_pulse_shape%0d", tag, i), bad_cnt[i], 0);
      check($sformatf("%s_busy%0d", tag, i), busy_v[i], 1'b0);
      check($sformatf("%s_valid%0d", tag, i), rx_valid_v[i], 1'b0);
    end
  endtask

  // Consumer stalled: first good byte is held, every later good byte overruns
  task automatic hold_batch(input string tag);
    logic       hv;
    logic [7:0] hb;
    new_phase();
    hv = 1'b0;
    hb = '0;
    @(posedge clk); #1 rx_ready = 1'b0;
    for (int n = 0; n < batch_b.size(); n++) begin
      if (batch_s[n]) begin
        if (!hv) begin hb = batch_b[n]; hv = 1'b1; end
        else exp_ov++;
      end else begin
        exp_fe++;
      end
      send(batch_b[n], batch_s[n], 8);
      if (!batch_s[n]) idle(2);
    end
    idle(1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_held_valid%0d", tag, i), rx_valid_v[i], hv);
      if (hv) check($sformatf("%s_held_data%0d", tag, i), rx_data_v[i], hb);
      check($sformatf("%s_held_overrun%0d", tag, i), ov_cnt[i], exp_ov);
    end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_cleared%0d", tag, i), rx_valid_v[i], 1'b0);
      if (hv) check($sformatf("%s_data_kept%0d", tag, i), rx_data_v[i], hb);
    end
    if (hv) exp_q.push_back(hb);
    verify(tag);
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    int unsigned g;

    rst_n    = 1'b0;
    line     = 1'b1;
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fe_cnt[i] = 0; ov_cnt[i] = 0; bad_cnt[i] = 0;
    end
    #3;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_data%0d", i), rx_data_v[i], 8'h00);
      check($sformatf("rst_valid%0d", i), rx_valid_v[i], 1'b0);
      check($sformatf("rst_frame_err%0d", i), fe_v[i], 1'b0);
      check($sformatf("rst_overrun%0d", i), ov_v[i], 1'b0);
      check($sformatf("rst_busy%0d", i), busy_v[i], 1'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    new_phase();
    model_frame(8'hA5, 1'b1);
    idle(2);
    verify("a5");

    batch_b = '{8'hAA, 8'h55};
    batch_s = '{1'b1, 1'b1};
    hold_batch("aa55");

    new_phase();
    model_frame(8'h3C, 1'b0);
    idle(1);
    verify("stop0");

    for (int it = 0; it < 4; it++) begin
      batch_b.delete();
      batch_s.delete();
      for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
        batch_b.push_back(8'($urandom));
        batch_s.push_back($urandom_range(0, 6) != 0);
      end
      hold_batch($sformatf("hold%0d", it));
    end

    new_phase();
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 6) != 0);
      g = $urandom_range(0, 3);
      if (g == 3) begin
        line = 1'b0;
        #(10 * $urandom_range(4, 20));
        idle(2);
      end
      model_frame(b, s);
      if (g == 1) idle(1);
    end
    idle(2);
    verify("rand");

    new_phase();
    idle(1);
    line = 1'b0;
    #200;
    idle(2);
    model_frame(8'h3C, 1'b1);
    idle(2);
    verify("glitch");

    send(8'hFF, 1'b1, 4);
    line = 1'b1;
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #25;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst_data%0d", i), rx_data_v[i], 8'h00);
      check($sformatf("midrst_valid%0d", i), rx_valid_v[i], 1'b0);
      check($sformatf("midrst_frame_err%0d", i), fe_v[i], 1'b0);
      check($sformatf("midrst_overrun%0d", i), ov_v[i], 1'b0);
      check($sformatf("midrst_busy%0d", i), busy_v[i], 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    new_phase();
    model_frame(8'h81, 1'b1);
    idle(2);
    verify("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
